// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: IF/ID control encodings,
// fetch FSM states and the default reset PC.
package if_pkg;

  localparam logic [2:0] IFID_LOAD  = 3'b111;
  localparam logic [2:0] IFID_HOLD  = 3'b010;
  localparam logic [2:0] IFID_FLUSH = 3'b000;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  // Instruction addresses are word aligned; the low two bits never reach the PC.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: reset to RESET_PC, load an aligned redirect target,
// or advance by 4 (wrapping modulo 2^32). Redirect beats advance.
module if_pc_reg
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] pc_inc
);

  assign pc_inc = pc + 32'd4;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= align_pc(redirect_pc);
    end else if (advance) begin
      pc <= pc_inc;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues imem requests at the PC, buffers one response
// across decode stalls and drops stale responses after a redirect.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
//
// Memory handshake: imem_req is the request valid and imem_addr the address;
// imem_ready marks a response in imem_rdata and only counts while imem_req=1.
// The address never changes while a request waits for its response, unless a
// redirect moves it.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instruction,
  output logic [31:0]  pc_plus_4,
  output logic [2:0]   IF_ID_Write,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]  fetch_count,
  output logic [31:0]  stall_count,
`endif
  output fetch_state_e state_dbg
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_inc;
  logic         pc_advance;
  logic [31:0]  hold_instr;
  logic [31:0]  hold_pc4;

  // The PC moves on only when a response is accepted in S_REQ (buffered or not).
  always_comb begin
    pc_advance = 1'b0;
    if (!redirect_valid && (state == S_REQ) && imem_ready) begin
      pc_advance = 1'b1;
    end
  end

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (pc_advance),
    .pc             (pc),
    .pc_inc         (pc_inc)
  );

  assign imem_addr = pc;
  assign imem_req  = (state != S_HOLD);
  assign state_dbg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      instruction <= 32'h0;
      pc_plus_4   <= 32'h0;
      IF_ID_Write <= IFID_FLUSH;
      hold_instr  <= 32'h0;
      hold_pc4    <= 32'h0;
    end else if (redirect_valid) begin
      // Only a request still waiting in S_REQ/S_DISCARD leaves a stale response behind.
      instruction <= 32'h0;
      pc_plus_4   <= 32'h0;
      IF_ID_Write <= IFID_FLUSH;
      hold_instr  <= 32'h0;
      hold_pc4    <= 32'h0;
      if ((state != S_HOLD) && !imem_ready) begin
        state <= S_DISCARD;
      end else begin
        state <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready && !stall) begin
            instruction <= imem_rdata;
            pc_plus_4   <= pc_inc;
            IF_ID_Write <= IFID_LOAD;
          end else if (imem_ready) begin
            hold_instr  <= imem_rdata;
            hold_pc4    <= pc_inc;
            IF_ID_Write <= IFID_HOLD;
            state       <= S_HOLD;
          end else begin
            IF_ID_Write <= stall ? IFID_HOLD : IFID_FLUSH;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instruction <= hold_instr;
            pc_plus_4   <= hold_pc4;
            IF_ID_Write <= IFID_LOAD;
            hold_instr  <= 32'h0;
            hold_pc4    <= 32'h0;
            state       <= S_REQ;
          end else begin
            IF_ID_Write <= IFID_HOLD;
          end
        end
        S_DISCARD: begin
          if (imem_ready) begin
            IF_ID_Write <= IFID_FLUSH;
            state       <= S_REQ;
          end else begin
            IF_ID_Write <= stall ? IFID_HOLD : IFID_FLUSH;
          end
        end
        default: begin
          IF_ID_Write <= IFID_FLUSH;
          state       <= S_REQ;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (IF_ID_Write == IFID_LOAD) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (IF_ID_Write == IFID_HOLD) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, hazard hold request from decode.
REQ-005 SHALL have port redirect_valid, input, 1, branch/jump taken this cycle.
REQ-006 SHALL have port redirect_pc, input, 32, redirect target; bits [1:0] ignored and treated as 0.
REQ-007 SHALL have port imem_req, output, 1, instruction-memory request valid.
REQ-008 SHALL have port imem_addr, output, 32, fetch address; always equals current PC.
REQ-009 SHALL have port imem_ready, input, 1, response valid; sampled only while imem_req=1.
REQ-010 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-011 SHALL have port instruction, output, 32, registered instruction to IF/ID register.
REQ-012 SHALL have port pc_plus_4, output, 32, registered fetch address + 4 of that instruction.
REQ-013 SHALL have port IF_ID_Write, output, 3, IF/ID control: 3'b111 load, 3'b010 hold, 3'b000 flush/bubble.

Function
REQ-014 SHALL implement a 3-state FSM: S_REQ (request outstanding), S_HOLD (response buffered during stall), S_DISCARD (drop stale response after redirect).
REQ-015 SHALL assert imem_req in S_REQ and S_DISCARD; deasserted in S_HOLD.
REQ-016 SHALL, in S_REQ with imem_ready=1, stall=0, redirect_valid=0: register instruction<=imem_rdata, pc_plus_4<=PC+4, IF_ID_Write<=3'b111, PC<=PC+4; stay in S_REQ (1-cycle latency ready-to-output).
REQ-017 SHALL, in S_REQ with imem_ready=0 and no redirect: hold PC, IF_ID_Write<=3'b000 (stall=0) or 3'b010 (stall=1).
REQ-018 SHALL, in S_REQ with imem_ready=1 and stall=1: capture imem_rdata and PC+4 into a 1-entry hold buffer, PC<=PC+4, IF_ID_Write<=3'b010, go S_HOLD.
REQ-019 SHALL, in S_HOLD with stall=0: drive buffer to instruction/pc_plus_4 with IF_ID_Write<=3'b111, go S_REQ; with stall=1 stay, IF_ID_Write<=3'b010.
REQ-020 SHALL give redirect_valid priority over stall and imem_ready in every state: PC<=redirect_pc, hold buffer cleared, IF_ID_Write<=3'b000, instruction/pc_plus_4<=0.
REQ-021 SHALL, on redirect in S_REQ with imem_ready=0, enter S_DISCARD; in S_DISCARD the first imem_ready is dropped and FSM returns to S_REQ at the redirected PC.
REQ-022 SHALL, on redirect with imem_ready=1 same cycle, drop the response and stay/return to S_REQ.
REQ-023 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-024 SHALL keep imem_addr stable while imem_req=1 and imem_ready=0, except on redirect.

Reset
REQ-025 SHALL, on reset=1 at any time, asynchronously set PC=RESET_PC, state=S_REQ, instruction=0, pc_plus_4=0, IF_ID_Write=3'b000, buffer cleared, counters cleared.
REQ-026 SHALL discard any outstanding memory response in flight at reset assertion; first request after release is at RESET_PC.

Configuration
REQ-027 SHALL support macro IF_PERF_CNT_EN: when defined, add outputs fetch_count (32) and stall_count (32), incrementing on each 3'b111 and each 3'b010 cycle respectively, wrapping modulo 2^32.
REQ-028 SHALL, without IF_PERF_CNT_EN, omit those ports and counter logic entirely; all other behaviour identical.

Structure
REQ-029 SHALL place IF_ID_Write encodings (IFID_LOAD, IFID_HOLD, IFID_FLUSH), FSM state enum and default RESET_PC in shared package if_pkg.
REQ-030 SHALL implement the PC register with reset/redirect/increment as sub-module if_pc_reg; FSM and output registers stay in if_fetch_stage.

Verification
REQ-031 SHALL cover: reset release, RESET_PC=0, imem_ready always 1, rdata=32'h1000_0004 -> next cycle instruction=32'h1000_0004, pc_plus_4=4, IF_ID_Write=3'b111; imem_addr=4.
REQ-032 SHALL cover: imem_ready=1 with stall=1 for 3 cycles at PC=8 -> IF_ID_Write=3'b010 for 3 cycles, imem_req=0, then 3'b111 with pc_plus_4=12.
REQ-033 SHALL cover: redirect_valid=1, redirect_pc=32'h40, while imem_ready=0 -> IF_ID_Write=3'b000, next imem_ready response dropped, following request imem_addr=32'h40.
REQ-034 SHALL cover: redirect_valid and stall both 1 with imem_ready=1 -> redirect wins, flush 3'b000, imem_addr=redirect_pc.
REQ-035 SHALL cover: PC=32'hFFFF_FFFC fetch -> pc_plus_4=0 and next imem_addr=0.
REQ-036 SHALL cover: reset asserted mid-S_HOLD -> all outputs 0 immediately, no buffered instruction delivered after release.
